// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-client memory arbiter: FSM encoding and client indices.
// Client 0 is the instruction cache, client 1 the data cache.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic ICACHE = 1'b0;
   localparam logic DCACHE = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie the client that did not win last time is chosen.
module rr_pick2
   import mem_arbiter_pkg::*;
(
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last_grant,
   output logic o_valid,
   output logic o_grant
);

   always_comb begin
      o_valid = i_req0 | i_req1;
      if (i_req0 && i_req1) begin
         o_grant = ~i_last_grant;
      end else if (i_req0) begin
         o_grant = ICACHE;
      end else begin
         o_grant = DCACHE;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache misses onto one memory port (IDLE -> BUSY -> DONE per
// transaction) and counts completed transactions per client.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  c0_r,
   input  logic                  c0_w,
   input  logic [ADDR_WIDTH-1:0] c0_addr,
   input  logic [DATA_WIDTH-1:0] c0_w_data,
   output logic [DATA_WIDTH-1:0] c0_r_data,
   output logic                  c0_ready,
   input  logic                  c1_r,
   input  logic                  c1_w,
   input  logic [ADDR_WIDTH-1:0] c1_addr,
   input  logic [DATA_WIDTH-1:0] c1_w_data,
   output logic [DATA_WIDTH-1:0] c1_r_data,
   output logic                  c1_ready,
   output logic                  m_req,
   output logic                  m_we,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [DATA_WIDTH-1:0] m_w_data,
   input  logic [DATA_WIDTH-1:0] m_r_data,
   input  logic                  m_ack,
   output logic [CNT_WIDTH-1:0]  grant_cnt0,
   output logic [CNT_WIDTH-1:0]  grant_cnt1
);

   state_t                r_state;
   state_t                w_next_state;
   logic                  r_last_grant;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_w_data;
   logic [DATA_WIDTH-1:0] r_rdata_buf;
   logic [CNT_WIDTH-1:0]  r_cnt0;
   logic [CNT_WIDTH-1:0]  r_cnt1;

   logic w_req0;
   logic w_req1;
   logic w_valid;
   logic w_grant;
   logic w_busy;
   logic w_done;

   assign w_req0 = c0_r | c0_w;
   assign w_req1 = c1_r | c1_w;

   rr_pick2 u_pick (
      .i_req0       (w_req0),
      .i_req1       (w_req1),
      .i_last_grant (r_last_grant),
      .o_valid      (w_valid),
      .o_grant      (w_grant)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Requests are only looked at in IDLE; the DONE->IDLE bubble lets a client drop its request.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_valid) w_next_state = BUSY;
         BUSY:    if (m_ack)   w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // The latched grant also serves as the round-robin history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= DCACHE;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_w_data     <= '0;
         r_rdata_buf  <= '0;
         r_cnt0       <= '0;
         r_cnt1       <= '0;
      end else begin
         if (r_state == IDLE && w_valid) begin
            r_last_grant <= w_grant;
            r_we         <= (w_grant == DCACHE) ? c1_w      : c0_w;
            r_addr       <= (w_grant == DCACHE) ? c1_addr   : c0_addr;
            r_w_data     <= (w_grant == DCACHE) ? c1_w_data : c0_w_data;
         end
         if (r_state == BUSY && m_ack) begin
            r_rdata_buf <= m_r_data;
         end
         if (r_state == DONE) begin
            if (r_last_grant == ICACHE) begin
               r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
            end else begin
               r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
            end
         end
      end
   end

   always_comb begin
      w_busy    = (r_state == BUSY);
      w_done    = (r_state == DONE);
      m_req     = w_busy;
      m_we      = w_busy & r_we;
      m_addr    = w_busy ? r_addr   : '0;
      m_w_data  = w_busy ? r_w_data : '0;
      c0_ready  = w_done && (r_last_grant == ICACHE);
      c1_ready  = w_done && (r_last_grant == DCACHE);
      c0_r_data = c0_ready ? r_rdata_buf : '0;
      c1_r_data = c1_ready ? r_rdata_buf : '0;
   end

   assign grant_cnt0 = r_cnt0;
   assign grant_cnt1 = r_cnt1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: client driver tasks, a memory responder that checks
// each BUSY cycle against an expected-transaction queue, and a ready-pulse monitor.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int CW = 4;
   localparam int EW = 1 + AW + DW + DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          c0_r = 1'b0, c0_w = 1'b0, c1_r = 1'b0, c1_w = 1'b0;
   logic [AW-1:0] c0_addr = '0, c1_addr = '0;
   logic [DW-1:0] c0_w_data = '0, c1_w_data = '0;
   logic [DW-1:0] c0_r_data, c1_r_data;
   logic          c0_ready, c1_ready;
   logic          m_req, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_w_data;
   logic [DW-1:0] m_r_data = '0;
   logic          m_ack = 1'b0;
   logic [CW-1:0] grant_cnt0, grant_cnt1;

   int            n_vec = 0;
   int            n_miss = 0;
   int            ack_delay = 0;
   logic          inject_ack = 1'b0;
   int            pulses0 = 0, pulses1 = 0;
   int            exp_cnt0 = 0, exp_cnt1 = 0;
   logic [EW-1:0] exp_q[$];

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .c0_r       (c0_r),
      .c0_w       (c0_w),
      .c0_addr    (c0_addr),
      .c0_w_data  (c0_w_data),
      .c0_r_data  (c0_r_data),
      .c0_ready   (c0_ready),
      .c1_r       (c1_r),
      .c1_w       (c1_w),
      .c1_addr    (c1_addr),
      .c1_w_data  (c1_w_data),
      .c1_r_data  (c1_r_data),
      .c1_ready   (c1_ready),
      .m_req      (m_req),
      .m_we       (m_we),
      .m_addr     (m_addr),
      .m_w_data   (m_w_data),
      .m_r_data   (m_r_data),
      .m_ack      (m_ack),
      .grant_cnt0 (grant_cnt0),
      .grant_cnt1 (grant_cnt1)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [EW-1:0] make_entry(input logic we, input logic [AW-1:0] addr,
                                                input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
      return {we, addr, wdata, rdata};
   endfunction

   // Memory side: checks the presented transaction every BUSY cycle, acks after ack_delay extra cycles.
   initial begin
      int            wait_cnt;
      logic [EW-1:0] e;
      wait_cnt = 0;
      forever begin
         @(negedge clk);
         m_ack = inject_ack;
         if (inject_ack) m_r_data = 32'hBAD0_BAD0;
         if (rst || !m_req) begin
            wait_cnt = 0;
         end else begin
            check_vec("m_req_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q[0];
               check_vec("m_we", m_we, e[EW-1]);
               check_vec("m_addr", m_addr, e[EW-2 -: AW]);
               check_vec("m_w_data", m_w_data, e[2*DW-1 -: DW]);
               wait_cnt++;
               if (wait_cnt > ack_delay) begin
                  m_ack    = 1'b1;
                  m_r_data = e[DW-1:0];
                  void'(exp_q.pop_front());
                  wait_cnt = 0;
               end
            end
         end
      end
   end

   // Ready pulses: one cycle wide, never both clients, r_data zero outside the pulse.
   initial begin
      logic prev0, prev1;
      prev0 = 1'b0;
      prev1 = 1'b0;
      forever begin
         @(negedge clk);
         if (c0_ready) begin
            pulses0++;
            check_vec("c0_ready_width", prev0, 1'b0);
            check_vec("ready_both", c1_ready, 1'b0);
         end else begin
            check_vec("c0_r_data_idle", c0_r_data, '0);
         end
         if (c1_ready) begin
            pulses1++;
            check_vec("c1_ready_width", prev1, 1'b0);
         end else begin
            check_vec("c1_r_data_idle", c1_r_data, '0);
         end
         prev0 = c0_ready;
         prev1 = c1_ready;
      end
   end

   task automatic client_txn(input int c, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                             input int exp_lat);
      int            lat;
      logic          got;
      logic [DW-1:0] rd;
      if (c == 0) begin
         c0_r = !we; c0_w = we; c0_addr = addr; c0_w_data = wdata;
      end else begin
         c1_r = !we; c1_w = we; c1_addr = addr; c1_w_data = wdata;
      end
      got = 1'b0;
      lat = 0;
      rd  = '0;
      while (!got && lat < 200) begin
         @(negedge clk);
         lat++;
         got = (c == 0) ? c0_ready : c1_ready;
         rd  = (c == 0) ? c0_r_data : c1_r_data;
      end
      check_vec($sformatf("c%0d_ready_seen", c), got, 1'b1);
      if (got) begin
         check_vec($sformatf("c%0d_r_data", c), rd, exp_rdata);
         if (exp_lat != 0) check_vec($sformatf("c%0d_latency", c), lat, exp_lat);
         if (c == 0) exp_cnt0++;
         else exp_cnt1++;
      end
      if (c == 0) begin
         c0_r = 1'b0; c0_w = 1'b0; c0_addr = '0; c0_w_data = '0;
      end else begin
         c1_r = 1'b0; c1_w = 1'b0; c1_addr = '0; c1_w_data = '0;
      end
   endtask

   task automatic check_counters(input string tag);
      logic [31:0] e0, e1;
      e0 = exp_cnt0;
      e1 = exp_cnt1;
      check_vec({tag, "_grant_cnt0"}, grant_cnt0, e0[CW-1:0]);
      check_vec({tag, "_grant_cnt1"}, grant_cnt1, e1[CW-1:0]);
   endtask

   task automatic do_reset();
      c0_r = 1'b0; c0_w = 1'b0; c1_r = 1'b0; c1_w = 1'b0;
      inject_ack = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      exp_cnt0 = 0;
      exp_cnt1 = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int p0, p1;
      logic [AW-1:0] a;
      do_reset();

      // Reset state
      check_vec("rst_m_req", m_req, 1'b0);
      check_vec("rst_m_we", m_we, 1'b0);
      check_vec("rst_m_addr", m_addr, '0);
      check_vec("rst_m_w_data", m_w_data, '0);
      check_vec("rst_c0_ready", c0_ready, 1'b0);
      check_vec("rst_c1_ready", c1_ready, 1'b0);
      check_counters("rst");

      // Single read, memory acks two cycles after m_req rises
      ack_delay = 2;
      exp_q.push_back(make_entry(1'b0, 32'h100, '0, 32'hDEAD_BEEF));
      fork
         client_txn(0, 1'b0, 32'h100, '0, 32'hDEAD_BEEF, 4);
         begin
            @(negedge clk);
            check_vec("t1_m_req_rise", m_req, 1'b1);
         end
      join
      @(negedge clk);
      check_vec("t1_grant_cnt0", grant_cnt0, 4'd1);

      // Write from client 1; client 0 must see no pulse
      ack_delay = 1;
      p0 = pulses0;
      p1 = pulses1;
      exp_q.push_back(make_entry(1'b1, 32'h2000, 32'h1234_5678, 32'h0BAD_F00D));
      client_txn(1, 1'b1, 32'h2000, 32'h1234_5678, 32'h0BAD_F00D, 3);
      @(negedge clk);
      check_vec("t2_c0_pulses", pulses0, p0);
      check_vec("t2_c1_pulses", pulses1, p1 + 1);
      check_vec("t2_grant_cnt1", grant_cnt1, 4'd1);

      // Ties after reset alternate c0, c1, c0, c1
      do_reset();
      ack_delay = 1;
      exp_q.push_back(make_entry(1'b0, 32'h1000, '0, 32'hA0A0_0001));
      exp_q.push_back(make_entry(1'b0, 32'h1100, '0, 32'hA0A0_0002));
      exp_q.push_back(make_entry(1'b0, 32'h1200, '0, 32'hA0A0_0003));
      exp_q.push_back(make_entry(1'b0, 32'h1300, '0, 32'hA0A0_0004));
      fork
         begin
            client_txn(0, 1'b0, 32'h1000, '0, 32'hA0A0_0001, 3);
            @(negedge clk);
            client_txn(0, 1'b0, 32'h1200, '0, 32'hA0A0_0003, 0);
         end
         begin
            client_txn(1, 1'b0, 32'h1100, '0, 32'hA0A0_0002, 0);
            @(negedge clk);
            client_txn(1, 1'b0, 32'h1300, '0, 32'hA0A0_0004, 0);
         end
      join
      @(negedge clk);
      check_vec("t3_queue_drained", exp_q.size(), 0);
      check_counters("t3");

      // Write-back then refill on c1 with c0 read interleaved
      exp_q.push_back(make_entry(1'b1, 32'h40, 32'h5555_AAAA, 32'h0000_0B0B));
      exp_q.push_back(make_entry(1'b0, 32'h300, '0, 32'hC0C0_0300));
      exp_q.push_back(make_entry(1'b0, 32'h80, '0, 32'hD1D1_0080));
      fork
         begin
            client_txn(1, 1'b1, 32'h40, 32'h5555_AAAA, 32'h0000_0B0B, 3);
            @(negedge clk);
            client_txn(1, 1'b0, 32'h80, '0, 32'hD1D1_0080, 0);
         end
         begin
            @(negedge clk);
            client_txn(0, 1'b0, 32'h300, '0, 32'hC0C0_0300, 0);
         end
      join
      @(negedge clk);
      check_vec("t4_queue_drained", exp_q.size(), 0);
      check_counters("t4");

      // Reset in the middle of BUSY; late ack must be ignored
      ack_delay = 20;
      exp_q.push_back(make_entry(1'b0, 32'h700, '0, 32'h7777_7777));
      c0_r = 1'b1;
      c0_addr = 32'h700;
      repeat (2) @(negedge clk);
      check_vec("t5_pre_rst_m_req", m_req, 1'b1);
      p0 = pulses0;
      p1 = pulses1;
      rst = 1'b1;
      #1;
      check_vec("t5_rst_m_req", m_req, 1'b0);
      check_vec("t5_rst_m_addr", m_addr, '0);
      check_vec("t5_rst_c0_ready", c0_ready, 1'b0);
      c0_r = 1'b0;
      c0_addr = '0;
      exp_q.delete();
      exp_cnt0 = 0;
      exp_cnt1 = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      inject_ack = 1'b1;
      repeat (2) @(negedge clk);
      inject_ack = 1'b0;
      repeat (3) @(negedge clk);
      check_vec("t5_no_pulse0", pulses0, p0);
      check_vec("t5_no_pulse1", pulses1, p1);
      check_vec("t5_m_req_idle", m_req, 1'b0);
      check_counters("t5");

      // Counter wrap with minimum round trip: 17 c0 transactions on a 4-bit counter
      do_reset();
      ack_delay = 0;
      for (int i = 0; i < 17; i++) begin
         a = 32'h4000 + 32'(i * 4);
         exp_q.push_back(make_entry(1'b0, a, '0, 32'(i + 1)));
         client_txn(0, 1'b0, a, '0, 32'(i + 1), 2);
         @(negedge clk);
         if (i == 15) check_vec("t6_wrap_to_zero", grant_cnt0, 4'd0);
      end
      check_vec("t6_grant_cnt0", grant_cnt0, 4'd1);
      check_vec("t6_grant_cnt1", grant_cnt1, 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      n_miss++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
